// File: rtl/uart_rx_full.sv
// UART receiver with 16x oversampling tick generator and little-endian word assembler.
// Optional even-parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_full #(
  parameter int unsigned DBIT    = 16,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DIV     = 163,
  parameter int unsigned SIZ     = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            rx,
  output logic [DBIT-1:0] o_Data,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned Lanes = DBIT / SIZ;
  localparam int unsigned CntW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW    = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int unsigned NW    = (SIZ > 1) ? $clog2(SIZ) : 1;
  localparam int unsigned IW    = (Lanes > 1) ? $clog2(Lanes) : 1;

  localparam logic [CntW-1:0] DivMax  = CntW'(DIV - 1);
  localparam logic [SW-1:0]   SHalf   = SW'(SB_TICK / 2 - 1);
  localparam logic [SW-1:0]   SLast   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]   NLast   = NW'(SIZ - 1);
  localparam logic [IW-1:0]   IdxLast = IW'(Lanes - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [SIZ-1:0]  b_q, b_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DBIT-1:0] word_q, word_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic [DBIT-1:0] word_ins;
  logic            tick;
`ifdef UART_RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            par_bad_q, par_bad_d;
`endif

  assign tick = (cnt_q == DivMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    idx_d    = idx_q;
    word_d   = word_q;
    data_d   = data_q;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    word_ins = word_q;
    word_ins[int'(idx_q) * SIZ +: SIZ] = b_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      StIdle: begin
        if (!rx) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == SHalf) begin
            // A start bit that is high again at its midpoint was a glitch
            if (!rx) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == SLast) begin
            s_d = '0;
            b_d = {rx, b_q[SIZ-1:1]};
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (s_q == SLast) begin
            s_d       = '0;
            par_bad_d = ^{b_q, rx};
            state_d   = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (s_q == SLast) begin
            state_d = StIdle;
            s_d     = '0;
            if (!rx) begin
              ferr_d = 1'b1;
              idx_d  = '0;
              word_d = '0;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
              idx_d  = '0;
              word_d = '0;
`endif
            end else if (idx_q == IdxLast) begin
              data_d = word_ins;
              done_d = 1'b1;
              idx_d  = '0;
              word_d = '0;
            end else begin
              word_d = word_ins;
              idx_d  = idx_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign o_Data    = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_full.sv
// Directed bench for uart_rx_full: serial frames driven bit by bit, outputs sampled on negedge.
// Uses DIV=4 so one bit is 64 clocks; parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx_full;
  localparam int Div  = 4;
  localparam int Bit  = 16 * Div;
`ifdef UART_RX_PARITY_EN
  localparam int FrameTicks = 8 + 16 * 8 + 16 + 16;
`else
  localparam int FrameTicks = 8 + 16 * 8 + 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] o_data;
  logic        done, ferr, perr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, done_cyc = 0;

  uart_rx_full #(.DBIT(16), .SB_TICK(16), .DIV(Div), .SIZ(8)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .rx        (rx),
    .o_Data    (o_data),
    .rx_done   (done),
    .frame_err (ferr),
    .parity_err(perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (perr) perr_cnt <= perr_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int len);
    rx = v;
    repeat (len) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    drive_bit(1'b0, Bit);
    for (int i = 0; i < 8; i++) drive_bit(d[i], Bit);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d, Bit);
`endif
    if (stop_ok) begin
      drive_bit(1'b1, Bit);
    end else begin
      // Bad stop ends before the receiver's immediate restart samples it as a start bit
      drive_bit(1'b0, Bit * 3 / 4);
      drive_bit(1'b1, Bit / 4);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    idle(Bit);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", o_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_loopback;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_word(16'h0004);
    checks++; if (o_data !== 16'h0004) begin errors++; $display("FAIL loop_data got %h want 0004", o_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL loop_done got %0d want 1", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL loop_ferr got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back;
    int d0, edge_cyc, lo, hi;
    d0 = done_cnt;
    send_byte(8'h34, 1'b1);
    edge_cyc = cyc;
    send_byte(8'h12, 1'b1);
    idle(Bit);
    lo = edge_cyc + 2 + (FrameTicks - 1) * Div;
    hi = edge_cyc + 1 + FrameTicks * Div;
    checks++; if (o_data !== 16'h1234) begin errors++; $display("FAIL b2b_data got %h want 1234", o_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_done got %0d want 1", done_cnt - d0); end
    checks++;
    if (done_cyc < lo || done_cyc > hi) begin
      errors++; $display("FAIL b2b_latency got %0d want %0d..%0d", done_cyc - edge_cyc, lo - edge_cyc, hi - edge_cyc);
    end
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 3 * Bit);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got %0d want 0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); end
    checks++; if (o_data !== 16'h1234) begin errors++; $display("FAIL glitch_hold got %h want 1234", o_data); end
    send_word(16'hBEEF);
    checks++; if (o_data !== 16'hBEEF) begin errors++; $display("FAIL glitch_next got %h want beef", o_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_next_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(2 * Bit);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_nodone got %0d want 0", done_cnt - d0); end
    checks++; if (o_data !== 16'hBEEF) begin errors++; $display("FAIL ferr_hold got %h want beef", o_data); end
    send_word(16'hABCD);
    checks++; if (o_data !== 16'hABCD) begin errors++; $display("FAIL ferr_next got %h want abcd", o_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ferr_next_done got %0d want 1", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_total got %0d want 1", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int d0;
    logic [7:0] b;
    send_word(16'h1234);
    checks++; if (o_data !== 16'h1234) begin errors++; $display("FAIL rmid_pre got %h want 1234", o_data); end
    d0 = done_cnt;
    b = 8'h5A;
    send_byte(b, 1'b1);
    drive_bit(1'b0, Bit);
    for (int i = 0; i < 4; i++) drive_bit(b[i], Bit);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL rmid_clear got %h want 0000", o_data); end
    @(negedge clk);
    rst = 1'b0;
    idle(Bit);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rmid_nodone got %0d want 0", done_cnt - d0); end
    send_word(16'h00FF);
    checks++; if (o_data !== 16'h00FF) begin errors++; $display("FAIL rmid_next got %h want 00ff", o_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rmid_next_done got %0d want 1", done_cnt - d0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int d0, f0, p0;
    d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    // 8'h01 needs parity bit 1 for even parity; send 0 instead
    drive_bit(1'b0, Bit);
    for (int i = 0; i < 8; i++) drive_bit(i == 0, Bit);
    drive_bit(1'b0, Bit);
    drive_bit(1'b1, Bit);
    idle(Bit);
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL par_pulse got %0d want 1", perr_cnt - p0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL par_nodone got %0d want 0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL par_noferr got %0d want 0", ferr_cnt - f0); end
    send_word(16'h0001);
    checks++; if (o_data !== 16'h0001) begin errors++; $display("FAIL par_next got %h want 0001", o_data); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL par_next_done got %0d want 1", done_cnt - d0); end
  endtask
`else
  task automatic test_parity;
    checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL par_tied got %0d want 0", perr_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    test_reset;
    test_loopback;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
